// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, NOP encoding,
// fetch FSM state encodings and the IF/ID payload type.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_ENCODING     = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_slot_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter, pending-redirect register and next-PC selection.
module fetch_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        advance_i,
    output logic [31:0] pc_o,
    output logic [31:0] next_pc_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_valid_q, pend_valid_d;

    // A redirect arriving in the same cycle as a PC advance takes effect immediately.
    always_comb begin
        if (redirect_valid_i) begin
            next_pc_o = redirect_pc_i;
        end else if (pend_valid_q) begin
            next_pc_o = pend_pc_q;
        end else begin
            next_pc_o = pc_q + 32'd4;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        if (advance_i) begin
            pc_d         = next_pc_o;
            pend_valid_d = 1'b0;
        end else if (redirect_valid_i) begin
            pend_pc_d    = redirect_pc_i;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: one outstanding imem fetch, hold buffer, IF/ID register.
// Build option DELAY_SLOT_EN keeps the instruction after a branch (delay slot).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

`ifdef DELAY_SLOT_EN
    localparam bit KILL_ON_REDIRECT = 1'b0;
`else
    localparam bit KILL_ON_REDIRECT = 1'b1;
`endif

    fetch_state_e state_q, state_d;
    logic         req_en_q;
    logic         kill_q, kill_d;
    if_slot_t     hold_q;
    if_slot_t     id_q;
    logic         id_valid_q;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        squash, rsp, rsp_drop, rsp_park, rsp_deliver;
    logic        hold_exit, hold_deliver, advance, deliver;
    if_slot_t    deliver_slot;

    // squash drops whatever fetch is younger than the current IF/ID contents.
    assign squash       = flush | (redirect_valid & KILL_ON_REDIRECT);
    assign rsp          = (state_q == ST_WAIT) && imem_rvalid;
    assign rsp_drop     = kill_q | squash;
    assign rsp_park     = rsp && !rsp_drop && stall;
    assign rsp_deliver  = rsp && !rsp_drop && !stall;
    assign hold_exit    = (state_q == ST_HOLD) && (squash || !stall);
    assign hold_deliver = (state_q == ST_HOLD) && !squash && !stall;
    assign advance      = (rsp && !rsp_park) || hold_exit;
    assign deliver      = rsp_deliver || hold_deliver;
    assign deliver_slot = (state_q == ST_HOLD) ? hold_q : {pc, imem_rdata};

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .advance_i        (advance),
        .pc_o             (pc),
        .next_pc_o        (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_REQ;
            req_en_q <= 1'b0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_en_q <= 1'b1;
            kill_q   <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ:  if (imem_req && imem_gnt) state_d = ST_WAIT;
            ST_WAIT: if (imem_rvalid) state_d = rsp_park ? ST_HOLD : ST_REQ;
            ST_HOLD: if (hold_exit) state_d = ST_REQ;
            default: state_d = ST_REQ;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == ST_REQ) && req_en_q;
        imem_addr = pc;
    end

    // Kill marks the single outstanding (or about-to-be-granted) fetch for discard.
    always_comb begin
        kill_d = kill_q;
        if (rsp || state_q == ST_HOLD) begin
            kill_d = 1'b0;
        end else if (squash) begin
            kill_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data-only hold buffer and IF/ID payload are reset too so outputs are defined from reset.
            hold_q     <= '0;
            id_q       <= '{pc: 32'h0, instr: NOP_INSTR};
            id_valid_q <= 1'b0;
        end else begin
            if (rsp_park) begin
                hold_q <= {pc, imem_rdata};
            end
            if (flush) begin
                id_valid_q <= 1'b0;
                id_q.instr <= NOP_INSTR;
            end else if (!stall) begin
                id_valid_q <= deliver;
                if (deliver) begin
                    id_q <= deliver_slot;
                end
            end
        end
    end

    assign id_valid = id_valid_q;
    assign id_pc    = id_q.pc;
    assign id_instr = id_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: an imem responder model plus queues of
// expected fetch addresses and expected IF/ID deliveries.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] addr_q[$];

    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    int          gnt_budget = 0;
    int          gnt_block = 0;
    bit          rdata_ovr = 1'b0;
    logic [31:0] rdata_ovr_val = '0;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock: monitor IF/ID after the edge, then drive the imem responder.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (rst_n && !stall && !flush && id_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_id_valid", {31'd0, id_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("id_pc", id_pc, e[63:32]);
                check("id_instr", id_instr, e[31:0]);
            end
        end
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        if (mem_pend) begin
            if (mem_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = rdata_ovr ? rdata_ovr_val : instr_at(mem_addr);
                rdata_ovr   = 1'b0;
                mem_pend    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (imem_req && gnt_budget > 0) begin
            if (gnt_block > 0) begin
                gnt_block--;
            end else begin
                imem_gnt = 1'b1;
                gnt_budget--;
                mem_pend = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = mem_lat;
                if (addr_q.size() == 0) check("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
                else check("fetch_addr", imem_addr, addr_q.pop_front());
            end
        end
    endtask

    task automatic wait_delivered(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_gnt(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = imem_gnt;
        end
        check("wait_gnt", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_rvalid(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = imem_rvalid;
        end
        check("wait_rvalid", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_pc", id_pc, 32'd0);
        check("rst_instr", id_instr, NOP_ENCODING);
        rst_n = 1'b1;
        check("req_before_first_edge", {31'd0, imem_req}, 32'd0);

        // Back-to-back sequential fetches
        mem_lat = 1;
        gnt_budget = 3;
        for (int i = 0; i < 3; i++) begin
            addr_q.push_back(32'h3000 + 32'(4 * i));
            exp_q.push_back({32'h3000 + 32'(4 * i), instr_at(32'h3000 + 32'(4 * i))});
        end
        wait_delivered(30);

        // Grant withheld: request and address must hold
        gnt_budget = 1;
        gnt_block = 3;
        addr_q.push_back(32'h300C);
        exp_q.push_back({32'h300C, instr_at(32'h300C)});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nogt_req", {31'd0, imem_req}, 32'd1);
            check("nogt_addr", imem_addr, 32'h300C);
        end
        wait_delivered(20);

        // Stall while the response arrives -> hold buffer
        gnt_budget = 1;
        addr_q.push_back(32'h3010);
        rdata_ovr = 1'b1;
        rdata_ovr_val = 32'h2408_0001;
        wait_rvalid(20);
        stall = 1'b1;
        tick();
        check("hold_req", {31'd0, imem_req}, 32'd0);
        check("hold_id_valid", {31'd0, id_valid}, 32'd0);
        tick();
        tick();
        check("hold_req_later", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        exp_q.push_back({32'h3010, 32'h2408_0001});
        tick();
        check("hold_drain", 32'(exp_q.size()), 32'd0);
        check("hold_next_addr", imem_addr, 32'h3014);

        // Redirect while a fetch is in flight
        mem_lat = 3;
        gnt_budget = 2;
        addr_q.push_back(32'h3014);
        addr_q.push_back(32'h3100);
`ifdef DELAY_SLOT_EN
        exp_q.push_back({32'h3014, instr_at(32'h3014)});
`endif
        exp_q.push_back({32'h3100, instr_at(32'h3100)});
        wait_gnt(20);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h3100;
        tick();
        wait_delivered(30);

        // Flush together with stall while IF/ID is valid and a response returns
        mem_lat = 1;
        gnt_budget = 2;
        addr_q.push_back(32'h3104);
        addr_q.push_back(32'h3108);
        exp_q.push_back({32'h3104, instr_at(32'h3104)});
        wait_delivered(20);
        stall = 1'b1;
        check("pre_flush_valid", {31'd0, id_valid}, 32'd1);
        check("pre_flush_pc", id_pc, 32'h3104);
        tick();
        flush = 1'b1;
        tick();
        check("flush_valid", {31'd0, id_valid}, 32'd0);
        check("flush_instr", id_instr, NOP_ENCODING);
        check("flush_next_addr", imem_addr, 32'h310C);
        flush = 1'b0;
        stall = 1'b0;
        gnt_budget = 1;
        addr_q.push_back(32'h310C);
        exp_q.push_back({32'h310C, instr_at(32'h310C)});
        wait_delivered(20);

        // Reset in WAIT, then a spurious rvalid right after reset
        mem_lat = 5;
        gnt_budget = 1;
        addr_q.push_back(32'h3110);
        wait_gnt(20);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'd0, id_valid}, 32'd0);
        check("mid_rst_pc", id_pc, 32'd0);
        check("mid_rst_instr", id_instr, NOP_ENCODING);
        mem_pend = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        mem_lat = 1;
        gnt_budget = 1;
        addr_q.push_back(32'h3000);
        exp_q.push_back({32'h3000, instr_at(32'h3000)});
        tick();
        check("post_rst_valid", {31'd0, id_valid}, 32'd0);
        check("post_rst_addr", imem_addr, 32'h3000);
        wait_delivered(20);
        check("addr_queue_empty", 32'(addr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
